// File: rtl/adder_seq_ctrl_pkg.sv
// ============================================================================
//  Module      : adder_seq_pkg
//  Description : Shared types, slice width and saturation helpers for the
//                sequential multi-precision adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_seq_pkg;

   localparam int SLICE_W = 6;
   localparam int MAX_W   = SLICE_W * 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest positive two's-complement value of width w, zero-extended to MAX_W
   function automatic logic [MAX_W-1:0] sat_max(input int w);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Most negative two's-complement value of width w, zero-extended to MAX_W
   function automatic logic [MAX_W-1:0] sat_min(input int w);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i == w - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_seq_ctrl_if.sv
// ============================================================================
//  Module      : adder_seq_ctrl_if
//  Description : Request/response handshake bundle for adder_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_seq_ctrl_if #(
   parameter int SLICES = 4
);
   localparam int W = 6 * SLICES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         c_out;
   logic         overflow;
   logic         busy;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, c_out, overflow, busy
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, c_out, overflow, busy
   );

endinterface

`default_nettype wire

// File: rtl/adder_seq_ctrl_slice_adder6.sv
// ============================================================================
//  Module      : slice_adder6
//  Description : 6-bit ripple-carry adder exposing the carry into the MSB
//                so the caller can form signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_adder6
   import adder_seq_pkg::*;
(
   input  wire logic [SLICE_W-1:0] x,
   input  wire logic [SLICE_W-1:0] y,
   input  wire logic               c_in,
   output logic      [SLICE_W-1:0] sum,
   output logic                    c_out,
   output logic                    c_pen
);

   logic [SLICE_W:0] w_c;

   assign w_c[0] = c_in;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
      assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
   end

   assign c_out = w_c[SLICE_W];
   assign c_pen = w_c[SLICE_W-1];

endmodule

`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
// ============================================================================
//  Module      : adder_seq_ctrl
//  Description : Wide add/subtract built from one 6-bit slice adder, one
//                slice per clock, LSB first. Optional ADDER_SEQ_SAT_EN
//                replaces overflowing results with signed saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   adder_seq_ctrl_if.slave    bus
);

   localparam int W  = SLICE_W * SLICES;
   localparam int CW = $clog2(SLICES);

   state_t               r_state;
   logic [W-1:0]         r_a;
   logic [W-1:0]         r_b;
   logic [W-1:0]         r_result;
   logic                 r_carry;
   logic                 r_c_out;
   logic                 r_ovf;
   logic [CW-1:0]        r_cnt;

   logic [SLICE_W-1:0]   w_x;
   logic [SLICE_W-1:0]   w_y;
   logic [SLICE_W-1:0]   w_sum;
   logic                 w_c_out;
   logic                 w_c_pen;
   logic                 w_last;

   assign w_x    = r_a[r_cnt*SLICE_W +: SLICE_W];
   assign w_y    = r_b[r_cnt*SLICE_W +: SLICE_W];
   assign w_last = (r_cnt == CW'(SLICES - 1));

   slice_adder6 u_slice (
      .x     (w_x),
      .y     (w_y),
      .c_in  (r_carry),
      .sum   (w_sum),
      .c_out (w_c_out),
      .c_pen (w_c_pen)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  // Subtract is A + ~B + 1; the +1 rides in as the first carry
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_result[r_cnt*SLICE_W +: SLICE_W] <= w_sum;
               r_carry <= w_c_out;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_c_out <= w_c_out;
                  r_ovf   <= w_c_out ^ w_c_pen;
                  r_state <= DONE;
`ifdef ADDER_SEQ_SAT_EN
                  // Full-width overwrite takes precedence over the slice write
                  if (w_c_out ^ w_c_pen) begin
                     r_result <= r_a[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
                  end
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.result    = r_result;
   assign bus.c_out     = r_c_out;
   assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
// ============================================================================
//  Module      : tb_adder_seq_ctrl
//  Description : Self-checking bench for adder_seq_ctrl with directed and
//                random operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_seq_ctrl;

   localparam int SLICES = 4;
   localparam int W      = 6 * SLICES;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   adder_seq_ctrl_if #(.SLICES(SLICES)) bus ();

   adder_seq_ctrl #(.SLICES(SLICES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain W+1-bit arithmetic with the sign rule for overflow
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic co, output logic ov);
      logic [W:0] full;
      if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else   full = {1'b0, a} + {1'b0, b};
      r  = full[W-1:0];
      co = full[W];
      if (s) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
`ifdef ADDER_SEQ_SAT_EN
      if (ov) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic eco,
                        input logic eov, input bit hold);
      int n;
      @(negedge clk);
      chk({tag, " in_ready before"}, 64'(bus.in_ready), 64'd1);
      bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = ~s;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      chk({tag, " latency"}, 64'(n), 64'(SLICES + 1));
      chk({tag, " result"}, 64'(bus.result), 64'(er));
      chk({tag, " c_out"}, 64'(bus.c_out), 64'(eco));
      chk({tag, " overflow"}, 64'(bus.overflow), 64'(eov));
      chk({tag, " in_ready in DONE"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " busy in DONE"}, 64'(bus.busy), 64'd1);
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a = W'($urandom); bus.b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, " hold result"}, 64'(bus.result), 64'(er));
            chk({tag, " hold flags"}, 64'({bus.c_out, bus.overflow}), 64'({eco, eov}));
            chk({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
         end
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, " out_valid after ack"}, 64'(bus.out_valid), 64'd0);
      chk({tag, " in_ready after ack"}, 64'(bus.in_ready), 64'd1);
      chk({tag, " busy after ack"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, er;
      logic         rs, eco, eov;
      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.sub = 1'b0;
      #1;
      chk("reset result", 64'(bus.result), 64'd0);
      chk("reset flags", 64'({bus.c_out, bus.overflow}), 64'd0);
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset in_ready", 64'(bus.in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op("add carry chain", 24'h000001, 24'h00003F, 1'b0, 24'h000040, 1'b0, 1'b0, 1'b0);
      do_op("add wrap", 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0);
`ifdef ADDER_SEQ_SAT_EN
      do_op("add pos ovf", 24'h7FFFFF, 24'h000001, 1'b0, 24'h7FFFFF, 1'b0, 1'b1, 1'b0);
      do_op("sub neg ovf", 24'h800000, 24'h000001, 1'b1, 24'h800000, 1'b1, 1'b1, 1'b0);
`else
      do_op("add pos ovf", 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0);
      do_op("sub neg ovf", 24'h800000, 24'h000001, 1'b1, 24'h7FFFFF, 1'b1, 1'b1, 1'b0);
`endif
      do_op("sub borrow", 24'h000005, 24'h000007, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
      do_op("hold done", 24'h123456, 24'h0ABCDE, 1'b0, 24'h1CF134, 1'b0, 1'b0, 1'b1);

      // Requests presented during DONE must not have been queued
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no queued out_valid", 64'(bus.out_valid), 64'd0);
         chk("no queued busy", 64'(bus.busy), 64'd0);
      end

      // Reset asserted during the second RUN cycle
      @(negedge clk);
      bus.a = 24'h00FFFF; bus.b = 24'h000111; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun reset result", 64'(bus.result), 64'd0);
      chk("midrun reset flags", 64'({bus.c_out, bus.overflow}), 64'd0);
      chk("midrun reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrun reset busy", 64'(bus.busy), 64'd0);
      chk("midrun reset in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < SLICES + 3; i++) begin
         @(negedge clk);
         chk("post reset out_valid", 64'(bus.out_valid), 64'd0);
      end
      do_op("add after reset", 24'h00FFFF, 24'h000111, 1'b0, 24'h010110, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       begin ra = W'($urandom); rb = W'($urandom); end
            1:       begin ra = {1'b0, {(W-1){1'b1}}} - W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 7)); end
            2:       begin ra = {1'b1, {(W-1){1'b0}}} + W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 7)); end
            default: begin ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(0, 255)); end
         endcase
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, er, eco, eov);
         do_op($sformatf("random %0d", i), ra, rb, rs, er, eco, eov, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Multi-precision add/subtract sequencer that time-shares one 6-bit ripple-carry slice adder across a wide operand, one 6-bit slice per clock, LSB slice first. It owns operand capture, per-slice carry chaining, subtract encoding, and signed-overflow detection. It presents valid/ready handshakes on both sides, so any datapath master can issue wide arithmetic without instantiating a wide adder.

## Interface
Parameters:
- `SLICES`, default 4: number of 6-bit slices; operand width W = 6*SLICES, minimum 2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `a` in W: operand A.
- `b` in W: operand B.
- `sub` in 1: 0 = A+B, 1 = A−B.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `result` out W: sum or difference.
- `c_out` out 1: final carry out (subtract: 1 = no borrow).
- `overflow` out 1: two's-complement signed overflow.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch `a`;
  - latch `b`, bitwise-inverted if `sub`;
  - carry register ← `sub`; slice counter ← 0; go to RUN.
- RUN: slice k = counter. Slice adder gets `a[6k+5:6k]`, `b'[6k+5:6k]`, carry register.
  - Sum is written to `result[6k+5:6k]`; carry register ← slice cout.
  - Counter increments.
  - At k = SLICES−1: `c_out` ← slice cout; `overflow` ← cout(bit4) ^ cout(bit5) of that slice; go to DONE.
- DONE: `out_valid`=1. `result`, `c_out` and `overflow` are held stable until `out_valid`&&`out_ready`, then go to IDLE.
- `in_valid` outside IDLE is ignored and not queued. Operands are not required to stay stable after the accept edge.
- Arithmetic is modulo 2^W. No extra width on `result`.
- All registered outputs reset to 0: `result`, `c_out`, `overflow`, `out_valid`, `busy`. `in_ready` is 1 after reset (IDLE).
- Reset asserted mid-operation: the in-flight operation is dropped immediately, the FSM returns to IDLE, and no `out_valid` pulse occurs.

## Timing
- Accept edge = cycle 0. Slices are processed on cycles 1..SLICES. `out_valid` rises on the edge ending cycle SLICES: latency SLICES+1 clocks from accept to first visible `out_valid`.
- Minimum issue interval is SLICES+2 clocks: accept, SLICES RUN cycles, one DONE cycle with `out_ready`=1, return to IDLE.
- `in_ready` and `out_valid` are never high in the same cycle.
- Outputs are registered. `in_ready` and `busy` decode directly from state flops.
- The only combinational path is through the slice adder, 6-bit ripple depth.

## Configuration
- `ADDER_SEQ_SAT_EN` defined: when `overflow` is set, `result` is replaced in DONE by saturation.
  - Positive saturation 0 followed by all ones (0x7FFFFF at W=24) if A's MSB is 0.
  - Otherwise negative saturation 1 followed by zeros (0x800000).
  - `overflow` is still reported as 1. `c_out` is unchanged.
- Not defined: `result` wraps modulo 2^W; no saturation logic is synthesized.

## Structure
- Package `adder_seq_pkg`:
  - `SLICE_W`=6;
  - state typedef enum {IDLE, RUN, DONE};
  - functions `sat_max(W)` / `sat_min(W)`.
- Sub-module `slice_adder6`: 6-bit ripple adder with inputs x, y, c_in and outputs sum, c_out, and penultimate carry (for overflow). Instantiated once.
- Counter width is $clog2(SLICES).

## Test plan
- W=24, add a=0x000001, b=0x00003F → result 0x000040, c_out=0, overflow=0. Carry crosses slice 0→1. `out_valid` 5 clocks after accept.
- Add a=0xFFFFFF, b=0x000001 → result 0x000000, c_out=1, overflow=0.
- Add a=0x7FFFFF, b=0x000001 → overflow=1, c_out=0.
  - Result 0x800000 without `ADDER_SEQ_SAT_EN`.
  - Result 0x7FFFFF with it.
- Subtract a=0x000005, b=0x000007 → result 0xFFFFFE, c_out=0 (borrow), overflow=0. Subtract a=0x800000, b=0x000001 → overflow=1.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_valid`, `result` and flags stable; `in_ready`=0. A concurrent `in_valid` with new operands is not accepted.
- Assert `rst_n`=0 during the 2nd RUN cycle → all outputs 0 immediately. After release: `in_ready`=1, no stale `out_valid`, and the next add is correct.
